hull_multichannel_fifo: RTL and testbench

//  NUM_CH independent show-ahead FIFOs in one block, each 2**LOG_DEPTH x WIDTH flop storage.

---
 rtl/hull_multichannel_fifo_if.sv | 30 +++
 rtl/hull_multichannel_fifo.sv | 130 +++++++++++++
 tb/tb_hull_multichannel_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hull_multichannel_fifo_if.sv
// Bundle of per-channel FIFO request/status signals, flattened with channel i
// at bit offset i*WIDTH (data/q) or i*(LOG_DEPTH+1) (count).
interface hull_multichannel_fifo_if #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2
);
    logic [NUM_CH-1:0]               wrreq;
    logic [NUM_CH*WIDTH-1:0]         data;
    logic [NUM_CH-1:0]               rdreq;
    logic [NUM_CH-1:0]               flush;
    logic                            err_clr;
    logic [NUM_CH*WIDTH-1:0]         q;
    logic [NUM_CH-1:0]               empty;
    logic [NUM_CH-1:0]               full;
    logic [NUM_CH-1:0]               almost_full;
    logic [NUM_CH*(LOG_DEPTH+1)-1:0] count;
    logic [NUM_CH-1:0]               overflow;
    logic [NUM_CH-1:0]               underflow;

    modport master (
        output wrreq, data, rdreq, flush, err_clr,
        input  q, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wrreq, data, rdreq, flush, err_clr,
        output q, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/hull_multichannel_fifo.sv
// NUM_CH independent show-ahead flop FIFOs with occupancy, almost-full,
// synchronous flush and sticky overflow/underflow flags per channel.
module hull_mcf_lane #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wrreq,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_rdreq,
    input  logic                 i_flush,
    input  logic                 i_err_clr,
    output logic [WIDTH-1:0]     o_q,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_af,
    output logic [LOG_DEPTH:0]   o_count,
    output logic                 o_ovf,
    output logic                 o_udf
);
    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam int CW    = LOG_DEPTH + 1;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [LOG_DEPTH-1:0]        r_wr_ptr;
    logic [LOG_DEPTH-1:0]        r_rd_ptr;
    logic [CW-1:0]               r_count;
    logic                        r_empty;
    logic                        r_full;
    logic                        r_af;
    logic                        r_ovf;
    logic                        r_udf;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [CW-1:0] w_cnt_nxt;

    // A full FIFO still accepts a write when the head is popped the same cycle;
    // reads never fall through an empty FIFO.
    assign w_wr_ok   = i_wrreq & (~r_full | i_rdreq);
    assign w_rd_ok   = i_rdreq & ~r_empty;
    assign w_ovf_set = ~i_flush & i_wrreq & r_full & ~i_rdreq;
    assign w_udf_set = ~i_flush & i_rdreq & r_empty;
    assign w_cnt_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            // Set wins over a same-cycle clear.
            r_ovf <= (r_ovf & ~i_err_clr) | w_ovf_set;
            r_udf <= (r_udf & ~i_err_clr) | w_udf_set;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_empty  <= 1'b1;
                r_full   <= 1'b0;
                r_af     <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_mem[r_wr_ptr] <= i_data;
                    r_wr_ptr        <= r_wr_ptr + LOG_DEPTH'(1);
                end
                if (w_rd_ok)
                    r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
                r_count <= w_cnt_nxt;
                r_empty <= (w_cnt_nxt == '0);
                r_full  <= (w_cnt_nxt == CW'(DEPTH));
                r_af    <= (w_cnt_nxt >= CW'(AF_THRESH));
            end
        end
    end

    assign o_q     = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_af    = r_af;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;
endmodule

module hull_multichannel_fifo #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    hull_multichannel_fifo_if.slave  bus
);
    localparam int CW = LOG_DEPTH + 1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hull_mcf_lane #(
            .WIDTH     (WIDTH),
            .LOG_DEPTH (LOG_DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_lane (
            .i_clk     (i_clock),
            .i_rst     (i_reset),
            .i_wrreq   (bus.wrreq[g]),
            .i_data    (bus.data[g*WIDTH +: WIDTH]),
            .i_rdreq   (bus.rdreq[g]),
            .i_flush   (bus.flush[g]),
            .i_err_clr (bus.err_clr),
            .o_q       (bus.q[g*WIDTH +: WIDTH]),
            .o_empty   (bus.empty[g]),
            .o_full    (bus.full[g]),
            .o_af      (bus.almost_full[g]),
            .o_count   (bus.count[g*CW +: CW]),
            .o_ovf     (bus.overflow[g]),
            .o_udf     (bus.underflow[g])
        );
    end
endmodule

// File: tb/tb_hull_multichannel_fifo.sv
// Directed bench for hull_multichannel_fifo: fill/drain, full-with-pop,
// overflow, underflow, wrap, flush and asynchronous reset scenarios.
module tb_hull_multichannel_fifo;
    localparam int NC = 4;
    localparam int W  = 32;
    localparam int LD = 2;
    localparam int CW = LD + 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    hull_multichannel_fifo_if #(.NUM_CH(NC), .WIDTH(W), .LOG_DEPTH(LD)) bus ();

    hull_multichannel_fifo #(.NUM_CH(NC), .WIDTH(W), .LOG_DEPTH(LD), .AF_THRESH(3)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wrreq   = '0;
        bus.rdreq   = '0;
        bus.flush   = '0;
        bus.err_clr = 1'b0;
        bus.data    = '0;
    endtask

    function automatic logic [W-1:0] q_of(int ch);
        return bus.q[ch*W +: W];
    endfunction

    function automatic logic [CW-1:0] cnt_of(int ch);
        return bus.count[ch*CW +: CW];
    endfunction

    task automatic wr(int ch, logic [W-1:0] v);
        bus.wrreq[ch]       = 1'b1;
        bus.data[ch*W +: W] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL reset_empty got %h want f", bus.empty); end
        checks++; if (bus.full !== 4'h0 || bus.almost_full !== 4'h0) begin errors++; $display("FAIL reset_full got %h/%h want 0/0", bus.full, bus.almost_full); end
        checks++; if (bus.count !== '0 || bus.q !== '0) begin errors++; $display("FAIL reset_cnt_q got %h/%h want 0", bus.count, bus.q); end
        checks++; if (bus.overflow !== 4'h0 || bus.underflow !== 4'h0) begin errors++; $display("FAIL reset_flags got %h/%h want 0/0", bus.overflow, bus.underflow); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [W-1:0] vals [4];
        vals = '{32'hA, 32'hB, 32'hC, 32'hD};
        for (int i = 0; i < 4; i++) begin
            idle(); wr(0, vals[i]); tick();
            checks++; if (cnt_of(0) !== CW'(i+1)) begin errors++; $display("FAIL fill_count%0d got %0d want %0d", i, cnt_of(0), i+1); end
            checks++; if (bus.almost_full[0] !== (i >= 2)) begin errors++; $display("FAIL fill_af%0d got %b want %b", i, bus.almost_full[0], i >= 2); end
            checks++; if (bus.full[0] !== (i == 3)) begin errors++; $display("FAIL fill_full%0d got %b want %b", i, bus.full[0], i == 3); end
            checks++; if (q_of(0) !== 32'hA || bus.empty[0] !== 1'b0) begin errors++; $display("FAIL fill_head%0d got %h/%b want a/0", i, q_of(0), bus.empty[0]); end
        end
        checks++; if (bus.empty[3:1] !== 3'b111) begin errors++; $display("FAIL fill_others got %b want 111", bus.empty[3:1]); end
        idle();
    endtask

    task automatic test_full_wr_rd();
        logic [W-1:0] exp [4];
        exp = '{32'hB, 32'hC, 32'hD, 32'hE};
        idle(); wr(0, 32'hE); bus.rdreq[0] = 1'b1; tick();
        checks++; if (q_of(0) !== 32'hB || cnt_of(0) !== 3'd4) begin errors++; $display("FAIL fullpop_q_cnt got %h/%0d want b/4", q_of(0), cnt_of(0)); end
        checks++; if (bus.overflow[0] !== 1'b0 || bus.full[0] !== 1'b1) begin errors++; $display("FAIL fullpop_flags got ovf=%b full=%b want 0/1", bus.overflow[0], bus.full[0]); end
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++; if (q_of(0) !== exp[i]) begin errors++; $display("FAIL drain%0d got %h want %h", i, q_of(0), exp[i]); end
            bus.rdreq[0] = 1'b1; tick();
        end
        idle();
        checks++; if (bus.empty[0] !== 1'b1 || cnt_of(0) !== 3'd0) begin errors++; $display("FAIL drain_empty got %b/%0d want 1/0", bus.empty[0], cnt_of(0)); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin idle(); wr(0, 32'h10 + i); tick(); end
        idle(); wr(0, 32'h99); tick();
        checks++; if (bus.overflow[0] !== 1'b1 || cnt_of(0) !== 3'd4 || q_of(0) !== 32'h10) begin errors++; $display("FAIL ovf_set got %b/%0d/%h want 1/4/10", bus.overflow[0], cnt_of(0), q_of(0)); end
        idle(); tick();
        checks++; if (bus.overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow[0]); end
        idle(); bus.err_clr = 1'b1; tick();
        checks++; if (bus.overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", bus.overflow[0]); end
        idle(); bus.flush[0] = 1'b1; tick();
        checks++; if (bus.empty[0] !== 1'b1 || bus.full[0] !== 1'b0 || bus.almost_full[0] !== 1'b0) begin errors++; $display("FAIL ovf_flush got e=%b f=%b af=%b want 1/0/0", bus.empty[0], bus.full[0], bus.almost_full[0]); end
        idle();
    endtask

    task automatic test_underflow();
        idle(); wr(1, 32'h55); bus.rdreq[1] = 1'b1; tick();
        checks++; if (bus.underflow[1] !== 1'b1 || cnt_of(1) !== 3'd1 || q_of(1) !== 32'h55) begin errors++; $display("FAIL udf_set got %b/%0d/%h want 1/1/55", bus.underflow[1], cnt_of(1), q_of(1)); end
        idle(); bus.err_clr = 1'b1; tick();
        checks++; if (bus.underflow[1] !== 1'b0 || cnt_of(1) !== 3'd1) begin errors++; $display("FAIL udf_clr got %b/%0d want 0/1", bus.underflow[1], cnt_of(1)); end
        idle(); bus.rdreq[1] = 1'b1; tick();
        checks++; if (bus.underflow[1] !== 1'b0 || bus.empty[1] !== 1'b1) begin errors++; $display("FAIL udf_pop got %b/%b want 0/1", bus.underflow[1], bus.empty[1]); end
        idle(); bus.rdreq[1] = 1'b1; bus.err_clr = 1'b1; tick();
        checks++; if (bus.underflow[1] !== 1'b1) begin errors++; $display("FAIL udf_setwins got %b want 1", bus.underflow[1]); end
        idle(); bus.err_clr = 1'b1; tick();
        checks++; if (bus.underflow !== 4'h0 || bus.overflow !== 4'h0) begin errors++; $display("FAIL udf_clr2 got %h/%h want 0/0", bus.underflow, bus.overflow); end
        idle();
    endtask

    task automatic test_wrap();
        int rd_idx = 0;
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 6) wr(2, 32'h200 + c);
            if (c >= 2) begin
                checks++; if (q_of(2) !== 32'h200 + rd_idx) begin errors++; $display("FAIL wrap_q%0d got %h want %h", rd_idx, q_of(2), 32'h200 + rd_idx); end
                bus.rdreq[2] = 1'b1;
                rd_idx++;
            end
            tick();
            checks++; if (cnt_of(2) > 3'd4 || cnt_of(2) !== ((c < 2) ? CW'(c+1) : (c < 6) ? 3'd2 : CW'(7-c))) begin errors++; $display("FAIL wrap_cnt%0d got %0d", c, cnt_of(2)); end
        end
        idle();
        checks++; if (bus.empty[2] !== 1'b1 || bus.overflow[2] !== 1'b0 || bus.underflow[2] !== 1'b0) begin errors++; $display("FAIL wrap_end got e=%b o=%b u=%b want 1/0/0", bus.empty[2], bus.overflow[2], bus.underflow[2]); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin idle(); wr(3, 32'h30 + i); tick(); end
        checks++; if (cnt_of(3) !== 3'd3 || bus.almost_full[3] !== 1'b1) begin errors++; $display("FAIL flush_pre got %0d/%b want 3/1", cnt_of(3), bus.almost_full[3]); end
        idle(); bus.flush[3] = 1'b1; wr(3, 32'h3F); tick();
        checks++; if (bus.empty[3] !== 1'b1 || cnt_of(3) !== 3'd0 || bus.almost_full[3] !== 1'b0) begin errors++; $display("FAIL flush got e=%b c=%0d af=%b want 1/0/0", bus.empty[3], cnt_of(3), bus.almost_full[3]); end
        checks++; if (bus.overflow[3] !== 1'b0 || bus.underflow[3] !== 1'b0) begin errors++; $display("FAIL flush_flags got %b/%b want 0/0", bus.overflow[3], bus.underflow[3]); end
        idle(); wr(3, 32'h77); tick();
        checks++; if (q_of(3) !== 32'h77 || cnt_of(3) !== 3'd1) begin errors++; $display("FAIL flush_after got %h/%0d want 77/1", q_of(3), cnt_of(3)); end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            idle();
            for (int ch = 0; ch < NC; ch++) wr(ch, 32'h400 + ch);
            tick();
        end
        idle(); for (int ch = 0; ch < NC; ch++) wr(ch, 32'h500 + ch);
        bus.rdreq[1] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.empty !== 4'hF || bus.count !== '0) begin errors++; $display("FAIL midrst_empty got %h/%h want f/0", bus.empty, bus.count); end
        checks++; if (bus.q !== '0 || bus.full !== 4'h0 || bus.almost_full !== 4'h0) begin errors++; $display("FAIL midrst_q got q=%h f=%h af=%h want 0", bus.q, bus.full, bus.almost_full); end
        idle();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.empty !== 4'hF || bus.overflow !== 4'h0 || bus.underflow !== 4'h0) begin errors++; $display("FAIL postrst got e=%h o=%h u=%h", bus.empty, bus.overflow, bus.underflow); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_full_wr_rd();
        test_overflow();
        test_underflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
